uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Two-requester UART transmit scheduler. It arbitrates round-robin between two byte sources, accepts one byte at a time over a valid/ready handshake, and serializes it 8N1 (or 8N2) on `tx`. Bit timing comes from an internal baud-rate divider that it enables, restarts and stops per frame. It sits between the on-chip byte producers and the board's UART TX pin.

## Interface
- `ClkFrequency`, default 50000000: system clock frequency in Hz.
- `Baud`, default 115200: line rate in bit/s. `DIV = ClkFrequency/Baud` uses integer division, truncated. `DIV >= 2` is required; elaboration must fail otherwise.
- `StopBits`, default 1: number of stop bits. Legal values are 1 and 2.

- `clk`, input, 1: system clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req0_valid`, input, 1: requester 0 has a byte.
- `req0_data`, input, 8: requester 0 byte.
- `req0_ready`, output, 1: byte from requester 0 is accepted this cycle.
- `req1_valid`, input, 1: requester 1 has a byte.
- `req1_data`, input, 8: requester 1 byte.
- `req1_ready`, output, 1: byte from requester 1 is accepted this cycle.
- `tx`, output, 1: serial line. Idle level is high.
- `busy`, output, 1: a frame is in progress.
- `grant_id`, output, 1: requester whose byte is being, or was last, sent.

## Operation
- **FSM states:** IDLE, START, DATA, STOP.
- **Registers:** bit counter `cnt` (0..DIV-1), bit index `idx` (0..7), stop counter, shift register `sh[7:0]`, round-robin pointer `last`.
- **Arbitration:** combinational and evaluated only in IDLE.
  - Only one valid: that requester wins.
  - Both valid: the requester not equal to `last` wins.
  - `last` resets to 1, so requester 0 wins the first tie.
- **Ready:** `reqN_ready = (state==IDLE) && reqN_valid && (winner==N)`. Ready depends combinationally on valid, and at most one ready is high at a time. Ready is 0 in every non-IDLE state.
- **Acceptance** is a clock edge with `reqN_valid && reqN_ready`. On that edge:
  - `sh <= reqN_data`, `grant_id <= N`, `last <= N`, `cnt <= 0`, state goes to START.
  - Data is captured at acceptance. Later changes to `req_data` or `req_valid` have no effect on the frame in progress.
- **Divider:** `cnt` counts only when state is not IDLE. It wraps at DIV-1 and generates a bit-end strobe on that cycle. It restarts at 0 on each acceptance, so the start-bit edge is aligned to the acceptance edge.
- **START:** `tx=0`. On the bit-end strobe, go to DATA with `idx=0`.
- **DATA:** `tx=sh[0]`, LSB first. On each bit-end strobe, shift `sh` right and increment `idx`. On the strobe with `idx==7`, go to STOP.
- **STOP:** `tx=1` for StopBits bit periods. On the last bit-end strobe, go to IDLE.
- **busy:** `busy = (state != IDLE)`.
- **tx source:** `tx` is driven from a register, so there is no combinational glitch on the pin.
- **Reset values:** state=IDLE, `tx=1`, `busy=0`, `grant_id=0`, `last=1`, `cnt=0`, `idx=0`, `sh=0`. Ready outputs are then 0 unless a valid is high.
- **Reset mid-frame:** the frame aborts immediately and asynchronously. `tx` returns to 1 and `busy` to 0. The byte is lost and not retried.

## Timing
- **Acceptance edge T:** `tx` falls at T, registered. The start bit spans DIV cycles.
- **Bit k** (k=0..7) is on `tx` for cycles T+(k+1)·DIV through T+(k+2)·DIV-1.
- **Frame length:** (9+StopBits)·DIV cycles. `busy` is high for exactly that many cycles, starting the cycle after T.
- **Back-to-back frames:** on the first IDLE cycle after the stop bit(s), a pending valid is accepted in that same cycle. The next start bit follows the stop bit with zero idle cycles.
- **Valid while busy:** a requester asserting valid while `busy=1` sees ready=0. It must hold valid and data until ready.
- **Wait bound:** with both requesters continuously valid, grants alternate 0,1,0,1,... Neither requester waits more than one frame.

## Test plan
All scenarios use ClkFrequency=1000 and Baud=100, so DIV=10.
- **Reset:** rst_n=0 for 3 cycles -> `tx=1`, `busy=0`, `grant_id=0`, both readies 0 with valids low.
- **Single byte:** req0_valid with 0xA5 -> req0_ready high 1 cycle. `tx` then carries 0,1,0,1,0,0,1,0,1,1, each level held 10 cycles. `busy` is high for exactly 100 cycles, and `grant_id=0`.
- **Tie:** req0=0x11 and req1=0x22 asserted in the same cycle -> 0x11 is sent first and 0x22 immediately after, with no idle gap. `grant_id` goes 0 then 1, and total busy is 200 cycles.
- **Fairness:** both requesters hold valid continuously for 4 frames -> grants 0,1,0,1. Each ready pulses exactly once per frame.
- **Two stop bits:** StopBits=2 with byte 0xFF -> start bit, eight 1-bits, two stop bits. Frame length is 110 cycles.
- **Abort and recover:** rst_n pulsed low during data bit 3, then req1 sends 0x3C -> `tx` goes high asynchronously on reset. The following frame is clean and complete, and `grant_id=1`.

Source files
------------

// File: rtl/uart_tx_sched.sv
// Two-requester round-robin UART transmitter, 8N1 or 8N2 on a registered tx pin.
// Bit timing comes from an internal divider that restarts on every accepted byte.
module uart_tx_sched #(
    parameter int ClkFrequency = 50000000,
    parameter int Baud         = 115200,
    parameter int StopBits     = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       tx,
    output logic       busy,
    output logic       grant_id
);

    localparam int DIV = ClkFrequency / Baud;
    localparam int CW  = (DIV >= 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(DIV - 1);
    localparam logic          STOP_LAST = (StopBits == 2);

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_sched: ClkFrequency/Baud must be at least 2");
    end
    if (StopBits != 1 && StopBits != 2) begin : g_bad_stop
        $error("uart_tx_sched: StopBits must be 1 or 2");
    end

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic          stop_cnt;
    logic [7:0]    sh;
    logic          last;
    logic          tx_q;
    logic          grant_q;
    logic          winner;
    logic          accept;
    logic          bit_end;

    assign bit_end  = (state != IDLE) && (cnt == CNT_MAX);
    assign accept   = req0_ready || req1_ready;
    assign busy     = (state != IDLE);
    assign tx       = tx_q;
    assign grant_id = grant_q;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        winner = 1'b0;
        if (req0_valid && req1_valid) begin
            winner = ~last;
        end else if (req1_valid) begin
            winner = 1'b1;
        end
        req0_ready = (state == IDLE) && req0_valid && !winner;
        req1_ready = (state == IDLE) && req1_valid && winner;

        state_next = state;
        case (state)
            IDLE:  if (accept)                            state_next = START;
            START: if (bit_end)                           state_next = DATA;
            DATA:  if (bit_end && idx == 3'd7)            state_next = STOP;
            STOP:  if (bit_end && stop_cnt == STOP_LAST)  state_next = IDLE;
            default:                                      state_next = IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // tx is loaded with the level of the bit that starts at this edge, so the pin is glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            idx      <= 3'd0;
            stop_cnt <= 1'b0;
            sh       <= 8'h00;
            last     <= 1'b1;
            grant_q  <= 1'b0;
            tx_q     <= 1'b1;
        end else if (accept) begin
            sh       <= winner ? req1_data : req0_data;
            grant_q  <= winner;
            last     <= winner;
            cnt      <= '0;
            idx      <= 3'd0;
            stop_cnt <= 1'b0;
            tx_q     <= 1'b0;
        end else if (state != IDLE) begin
            cnt <= bit_end ? '0 : cnt + 1'b1;
            if (bit_end) begin
                case (state)
                    START: begin
                        tx_q <= sh[0];
                        idx  <= 3'd0;
                    end
                    DATA: begin
                        sh       <= sh >> 1;
                        idx      <= idx + 1'b1;
                        stop_cnt <= 1'b0;
                        tx_q     <= (idx == 3'd7) ? 1'b1 : sh[1];
                    end
                    STOP: begin
                        stop_cnt <= stop_cnt + 1'b1;
                        tx_q     <= 1'b1;
                    end
                    default: tx_q <= 1'b1;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: a cycle model predicts ready/busy and queues
// the expected frames; a line monitor decodes tx and compares against that queue.
module tb_uart_tx_sched;

    localparam int DIV = 10;
    localparam int F1  = 10 * DIV;
    localparam int F2  = 11 * DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       drv_valid [2];
    logic [7:0] drv_data  [2];
    logic       drv_busy  [2];
    logic       a_r0, a_r1, a_tx, a_busy, a_gid;
    logic       b_v0, b_v1, b_r0, b_r1, b_tx, b_busy, b_gid;
    logic [7:0] b_d0, b_d1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] byte_q0 [$];
    logic [7:0] byte_q1 [$];
    int         gap_q0  [$];
    int         gap_q1  [$];
    logic [8:0] sb_q    [$];
    logic [8:0] rx_log  [$];

    always #5 clk = ~clk;

    uart_tx_sched #(.ClkFrequency(1000), .Baud(100), .StopBits(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(drv_valid[0]), .req0_data(drv_data[0]), .req0_ready(a_r0),
        .req1_valid(drv_valid[1]), .req1_data(drv_data[1]), .req1_ready(a_r1),
        .tx(a_tx), .busy(a_busy), .grant_id(a_gid)
    );

    uart_tx_sched #(.ClkFrequency(1000), .Baud(100), .StopBits(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(b_v0), .req0_data(b_d0), .req0_ready(b_r0),
        .req1_valid(b_v1), .req1_data(b_d1), .req1_ready(b_r1),
        .tx(b_tx), .busy(b_busy), .grant_id(b_gid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic enq(input int n, input logic [7:0] d, input int gap);
        if (n == 0) begin
            byte_q0.push_back(d);
            gap_q0.push_back(gap);
        end else begin
            byte_q1.push_back(d);
            gap_q1.push_back(gap);
        end
    endtask

    // Producer: presents a byte after its gap and holds valid/data until ready.
    task automatic drive(input int n);
        logic [7:0] d;
        int         gap;
        bit         got;
        forever begin
            if ((n == 0 && byte_q0.size() == 0) || (n == 1 && byte_q1.size() == 0)) begin
                drv_valid[n] = 1'b0;
                @(posedge clk); #1;
            end else begin
                drv_busy[n] = 1'b1;
                if (n == 0) begin
                    d   = byte_q0.pop_front();
                    gap = gap_q0.pop_front();
                end else begin
                    d   = byte_q1.pop_front();
                    gap = gap_q1.pop_front();
                end
                if (gap > 0) begin
                    drv_valid[n] = 1'b0;
                    repeat (gap) @(posedge clk);
                    #1;
                end
                drv_valid[n] = 1'b1;
                drv_data[n]  = d;
                got = 1'b0;
                for (int c = 0; c < 4 * F1 && !got; c++) begin
                    @(negedge clk);
                    got = (n == 0) ? a_r0 : a_r1;
                    @(posedge clk); #1;
                end
                drv_data[n] = 8'($urandom);
                drv_busy[n] = 1'b0;
                check((n == 0) ? "req0_handshake" : "req1_handshake", 32'(got), 32'd1);
                if (!got) drv_valid[n] = 1'b0;
            end
        end
    endtask

    initial drive(0);
    initial drive(1);

    // Reference model: a frame occupies the line for F1 cycles; while free, a single
    // requester wins outright and a tie goes to whoever did not send last.
    int   busy_left = 0;
    logic m_last    = 1'b1;

    always @(negedge clk) begin : model
        logic idle, w, e_r0, e_r1;
        if (!rst_n) begin
            busy_left = 0;
            m_last    = 1'b1;
        end else begin
            idle = (busy_left == 0);
            if (!idle) busy_left--;
            if (drv_valid[0] && drv_valid[1]) w = ~m_last;
            else                              w = drv_valid[1];
            e_r0 = idle && drv_valid[0] && !w;
            e_r1 = idle && drv_valid[1] && w;
            check("ready0_ready1_busy", 32'({a_r0, a_r1, a_busy}), 32'({e_r0, e_r1, !idle}));
            if (e_r0 || e_r1) begin
                busy_left = F1;
                m_last    = w;
                sb_q.push_back({w, w ? drv_data[1] : drv_data[0]});
            end
        end
    end

    // Line monitor: every cycle of a frame must carry the expected level.
    initial begin : line_mon
        logic [8:0] exp;
        logic [9:0] levels, rx;
        logic       gid;
        int         bad;
        bit         abort;
        forever begin
            @(negedge clk);
            if (rst_n && a_tx === 1'b0) begin
                check("frame_expected", 32'(sb_q.size()), 32'd1);
                exp    = (sb_q.size() > 0) ? sb_q.pop_front() : 9'h1ff;
                gid    = a_gid;
                check("grant_id", 32'(gid), 32'(exp[8]));
                levels = {1'b1, exp[7:0], 1'b0};
                rx     = '0;
                bad    = 0;
                abort  = 1'b0;
                for (int j = 0; j < 10 && !abort; j++) begin
                    for (int c = 0; c < DIV && !abort; c++) begin
                        if (j != 0 || c != 0) @(negedge clk);
                        if (!rst_n) begin
                            abort = 1'b1;
                        end else begin
                            if (a_tx !== levels[j]) bad++;
                            if (c == DIV / 2) rx[j] = a_tx;
                        end
                    end
                end
                if (!abort) begin
                    check("frame_bits", 32'(rx), 32'(levels));
                    check("bit_timing_errors", 32'(bad), 32'd0);
                    rx_log.push_back({gid, rx[8:1]});
                    @(negedge clk);
                    if (rst_n) check("tx_after_stop", 32'(a_tx), 32'd1);
                end
            end
        end
    end

    task automatic wait_quiet(input int budget);
        bit done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            if (byte_q0.size() == 0 && byte_q1.size() == 0 && !drv_busy[0] && !drv_busy[1]
                && !a_busy && sb_q.size() == 0) done = 1'b1;
        end
        check("quiet_timeout", 32'(done), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin : main
        logic [7:0] f0 [2];
        logic [7:0] f1 [2];
        logic [8:0] exp_fair [4];
        int         errs, busy_n;
        bit         got;

        drv_valid[0] = 1'b0; drv_valid[1] = 1'b0;
        drv_data[0]  = 8'h00; drv_data[1]  = 8'h00;
        drv_busy[0]  = 1'b0; drv_busy[1]  = 1'b0;
        b_v0 = 1'b0; b_v1 = 1'b0; b_d0 = 8'h00; b_d1 = 8'h00;

        // Reset
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", 32'(a_tx), 32'd1);
        check("reset_busy", 32'(a_busy), 32'd0);
        check("reset_grant", 32'(a_gid), 32'd0);
        check("reset_ready", 32'({a_r0, a_r1}), 32'd0);
        check("reset_b_tx", 32'(b_tx), 32'd1);
        rst_n = 1'b1;

        // Tie from reset: requester 0 first, then requester 1 back to back
        @(negedge clk);
        rx_log.delete();
        enq(0, 8'h11, 0);
        enq(1, 8'h22, 0);
        wait_quiet(3 * F1);
        check("tie_frames", 32'(rx_log.size()), 32'd2);
        if (rx_log.size() >= 2) begin
            check("tie_first", 32'(rx_log[0]), 32'({1'b0, 8'h11}));
            check("tie_second", 32'(rx_log[1]), 32'({1'b1, 8'h22}));
        end

        // Fairness: both requesters continuously valid for four frames
        rx_log.delete();
        for (int i = 0; i < 2; i++) begin
            f0[i] = 8'($urandom);
            f1[i] = 8'($urandom);
            enq(0, f0[i], 0);
            enq(1, f1[i], 0);
        end
        exp_fair[0] = {1'b0, f0[0]};
        exp_fair[1] = {1'b1, f1[0]};
        exp_fair[2] = {1'b0, f0[1]};
        exp_fair[3] = {1'b1, f1[1]};
        wait_quiet(6 * F1);
        check("fair_frames", 32'(rx_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < rx_log.size(); i++)
            check("fair_order", 32'(rx_log[i]), 32'(exp_fair[i]));

        // Single byte 0xA5 from requester 0
        rx_log.delete();
        enq(0, 8'hA5, 0);
        wait_quiet(2 * F1);
        check("single_frames", 32'(rx_log.size()), 32'd1);
        if (rx_log.size() >= 1) check("single_byte", 32'(rx_log[0]), 32'({1'b0, 8'hA5}));

        // Randomized traffic with independent gaps per requester
        rx_log.delete();
        for (int i = 0; i < 12; i++) begin
            enq(0, 8'($urandom), int'($urandom_range(0, 150)));
            enq(1, 8'($urandom), int'($urandom_range(0, 150)));
        end
        wait_quiet(20000);
        check("random_frames", 32'(rx_log.size()), 32'd24);

        // Two stop bits on the second instance, byte 0xFF
        @(posedge clk); #1;
        b_v0 = 1'b1; b_d0 = 8'hFF;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            got = b_r0;
            @(posedge clk); #1;
        end
        b_v0 = 1'b0; b_d0 = 8'h00;
        check("b_handshake", 32'(got), 32'd1);
        errs = 0;
        busy_n = 0;
        for (int i = 0; i < F2 + 10; i++) begin
            @(negedge clk);
            if (b_tx !== ((i < DIV) ? 1'b0 : 1'b1)) errs++;
            if (b_busy) busy_n++;
        end
        check("b_tx_levels", 32'(errs), 32'd0);
        check("b_busy_cycles", 32'(busy_n), 32'(F2));
        check("b_grant", 32'(b_gid), 32'd0);

        // Abort during data bit 3, then a clean frame from requester 1
        rx_log.delete();
        enq(0, 8'h00, 0);
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            got = a_busy;
        end
        check("abort_frame_started", 32'(got), 32'd1);
        repeat (44) @(posedge clk);
        #2;
        check("abort_pre_tx", 32'(a_tx), 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_tx_async", 32'(a_tx), 32'd1);
        check("abort_busy_async", 32'(a_busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        enq(1, 8'h3C, 0);
        wait_quiet(3 * F1);
        check("recover_frames", 32'(rx_log.size()), 32'd1);
        if (rx_log.size() >= 1) check("recover_byte", 32'(rx_log[0]), 32'({1'b1, 8'h3C}));
        check("recover_grant", 32'(a_gid), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
